// File: rtl/usb_line_replay.sv
// usb_line_replay: buffers CH-bit D+/D- line samples and replays them onto the
// pads at a programmable rate. Playback is either one-shot (FIFO drain) or cyclic.
// Optional feature macro: USB_REPLAY_CNT_EN adds sample_cnt[15:0], the number of
// samples driven since the last accepted start.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | not playing; line_out follows idle_val one cycle late, pads off
// PLAY  | one-shot: every tick pops the oldest entry onto line_out
// LOOP  | cyclic: every tick shows the next stored entry, nothing is popped
module usb_line_replay #(
  parameter int CH    = 2,
  parameter int DEPTH = 16,
  parameter int DIV_W = 8
) (
  input  logic                     clk48,
  input  logic                     rst_n,
  input  logic [CH-1:0]            s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DIV_W-1:0]         div,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     flush,
  input  logic [CH-1:0]            idle_val,
  output logic [CH-1:0]            line_out,
  output logic                     line_oe,
  output logic                     busy,
  output logic                     done,
`ifdef USB_REPLAY_CNT_EN
  output logic [15:0]              sample_cnt,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_LOOP = 2'd2
  } state_t;

  state_t             state_q;
  logic [CH-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW-1:0]      off_q;
  logic [LW-1:0]      level_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   cnt_q;
  logic [CH-1:0]      line_out_q;
  logic               line_oe_q;
  logic               done_q;

  logic               flush_en;
  logic               push_en;
  logic               start_ok;
  logic               tick;
  logic               pop_en;
  logic               drive_en;
  logic [AW-1:0]      loop_idx;
  logic [CH-1:0]      rd_data;
  logic [CH-1:0]      loop_data;
  logic [LW-1:0]      level_d;

  // Handshake, tick and pointer-side decode shared by the FSM and the buffer.
  always_comb begin
    flush_en  = flush && (state_q == ST_IDLE);
    s_ready   = (level_q != LW'(DEPTH)) && (state_q != ST_LOOP);
    push_en   = s_valid && s_ready && !flush_en;
    start_ok  = (state_q == ST_IDLE) && start && !stop && (level_q != '0);
    tick      = (state_q != ST_IDLE) && (cnt_q == '0) && !stop;
    pop_en    = (start_ok && !loop) ||
                ((state_q == ST_PLAY) && tick && (level_q != '0));
    // a sample reaches line_out on start and on every tick that has data
    drive_en  = start_ok || (tick && ((state_q == ST_LOOP) || (level_q != '0)));
    loop_idx  = rd_ptr_q + off_q;
    rd_data   = mem_q[rd_ptr_q];
    loop_data = mem_q[loop_idx];
    if (flush_en) begin
      level_d = '0;
    end else begin
      level_d = level_q + LW'(push_en) - LW'(pop_en);
    end
  end

  // Sample storage; contents need no reset since level gates every read.
  always_ff @(posedge clk48) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // Playback FSM with registered pad outputs, pointers, level and rate divider.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      off_q      <= '0;
      level_q    <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      line_out_q <= '0;
      line_oe_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      level_q <= level_d;
      if (flush_en) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end

      case (state_q)
        ST_IDLE: begin
          line_oe_q  <= 1'b0;
          line_out_q <= idle_val;
          if (start_ok) begin
            // first sample goes out the cycle after start; div is frozen here
            div_q      <= div;
            cnt_q      <= div;
            line_oe_q  <= 1'b1;
            line_out_q <= rd_data;
            if (loop) begin
              state_q <= ST_LOOP;
              off_q   <= (level_q == LW'(1)) ? AW'(0) : AW'(1);
            end else begin
              state_q <= ST_PLAY;
            end
          end
        end

        ST_PLAY: begin
          if (stop) begin
            state_q    <= ST_IDLE;
            line_oe_q  <= 1'b0;
            line_out_q <= idle_val;
          end else if (cnt_q == '0) begin
            cnt_q <= div_q;
            if (level_q == '0) begin
              // pads stay on for the done cycle and drop on the next one
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              line_out_q <= rd_data;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end

        ST_LOOP: begin
          if (stop) begin
            state_q    <= ST_IDLE;
            line_oe_q  <= 1'b0;
            line_out_q <= idle_val;
          end else if (cnt_q == '0) begin
            cnt_q      <= div_q;
            line_out_q <= loop_data;
            off_q      <= ((LW'(off_q) + LW'(1)) == level_q) ? AW'(0) : off_q + AW'(1);
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          line_oe_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef USB_REPLAY_CNT_EN
  logic [15:0] sample_cnt_q;

  // Counts driven samples; start clears it and its own first sample counts as one.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
    end else if (start_ok) begin
      sample_cnt_q <= 16'd1;
    end else if (drive_en && (state_q != ST_IDLE) && (sample_cnt_q != 16'hFFFF)) begin
      sample_cnt_q <= sample_cnt_q + 16'd1;
    end
  end

  assign sample_cnt = sample_cnt_q;
`else
  logic unused_drive;
  assign unused_drive = drive_en;
`endif

  assign line_out = line_out_q;
  assign line_oe  = line_oe_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign level    = level_q;

endmodule

// File: tb/tb_usb_line_replay.sv
// Directed bench for usb_line_replay with hand-computed expectations.
module tb_usb_line_replay;

  localparam int CH    = 2;
  localparam int DEPTH = 16;
  localparam int DIV_W = 8;

  logic              clk48;
  logic              rst_n;
  logic [CH-1:0]     s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DIV_W-1:0]  div;
  logic              loop;
  logic              start;
  logic              stop;
  logic              flush;
  logic [CH-1:0]     idle_val;
  logic [CH-1:0]     line_out;
  logic              line_oe;
  logic              busy;
  logic              done;
  logic [4:0]        level;
`ifdef USB_REPLAY_CNT_EN
  logic [15:0]       sample_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  usb_line_replay #(.CH(CH), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk48    (clk48),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .div      (div),
    .loop     (loop),
    .start    (start),
    .stop     (stop),
    .flush    (flush),
    .idle_val (idle_val),
    .line_out (line_out),
    .line_oe  (line_oe),
    .busy     (busy),
    .done     (done),
`ifdef USB_REPLAY_CNT_EN
    .sample_cnt (sample_cnt),
`endif
    .level    (level)
  );

  initial clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk48);
    #1;
  endtask

  task automatic push(input logic [CH-1:0] v);
    s_data  = v;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [DIV_W-1:0] d, input logic lp);
    div   = d;
    loop  = lp;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [CH-1:0] seq4 [4];
  logic [CH-1:0] seq3 [3];
  int done_at;
  int done_cnt;

  initial begin
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; div = '0; loop = 1'b0;
    start = 1'b0; stop = 1'b0; flush = 1'b0; idle_val = 2'b10;
    seq4[0] = 2'd3; seq4[1] = 2'd1; seq4[2] = 2'd2; seq4[3] = 2'd0;
    seq3[0] = 2'd1; seq3[1] = 2'd2; seq3[2] = 2'd3;

    // reset state
    #12;
    chk("rst_line_out", line_out, 0);
    chk("rst_line_oe", line_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_level", level, 0);
    rst_n = 1'b1;
    step();
    chk("idle_val_follow", line_out, 2);
    chk("idle_ready", s_ready, 1);

    // one-shot 3,1,2,0 at div=0
    for (int i = 0; i < 4; i++) push(seq4[i]);
    chk("load4_level", level, 4);
    pulse_start(8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("os_line_out", line_out, seq4[i]);
      chk("os_level", level, 3 - i);
      chk("os_oe", line_oe, 1);
      chk("os_done_low", done, 0);
      if (i < 3) step();
    end
    step();
    chk("os_done_pulse", done, 1);
    chk("os_busy_off", busy, 0);
    chk("os_oe_hold", line_oe, 1);
    step();
    chk("os_done_clear", done, 0);
    chk("os_oe_off", line_oe, 0);
    chk("os_idle_out", line_out, 2);

    // div=3: two samples four clocks apart
    idle_val = 2'b00;
    push(2'd1);
    push(2'd2);
    pulse_start(8'd3, 1'b0);
    done_at = -1;
    for (int i = 0; i < 14; i++) begin
      if (i <= 7) chk("d3_line_out", line_out, (i < 4) ? 1 : 2);
      if (i == 0) chk("d3_level_a", level, 1);
      if (i == 4) chk("d3_level_b", level, 0);
      if (done === 1'b1 && done_at < 0) done_at = i;
      step();
    end
    chk("d3_done_cycle", done_at, 8);
    chk("d3_idle", busy, 0);

    // start with empty buffer is ignored
    pulse_start(8'd0, 1'b0);
    chk("empty_start_busy", busy, 0);
    chk("empty_start_done", done, 0);
    step();
    chk("empty_start_done2", done, 0);
    chk("empty_start_oe", line_oe, 0);

    // fill to full, blocked 17th push, flush
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_ready", s_ready, 1);
      push(2'(i));
    end
    chk("full_level", level, 16);
    chk("full_ready", s_ready, 0);
    push(2'd3);
    chk("full_hold_level", level, 16);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_ready", s_ready, 1);
    // flush and push in the same cycle: sample dropped
    s_data = 2'd1; s_valid = 1'b1; flush = 1'b1;
    step();
    s_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_push", level, 0);

    // loop replay 1,2,3 at div=1
    for (int i = 0; i < 3; i++) push(seq3[i]);
    pulse_start(8'd1, 1'b1);
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      chk("loop_line_out", line_out, seq3[(i / 2) % 3]);
      if (done === 1'b1) done_cnt++;
      if (i == 5) begin
        chk("loop_level", level, 3);
        chk("loop_ready", s_ready, 0);
        chk("loop_busy", busy, 1);
      end
      step();
    end
    chk("loop_no_done", done_cnt, 0);
    // flush is ignored outside IDLE
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("loop_flush_ign", level, 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("loop_stop_busy", busy, 0);
    chk("loop_stop_oe", line_oe, 0);
    chk("loop_stop_level", level, 3);

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", busy, 0);
    chk("start_stop_level", level, 3);

    // stop mid-play keeps unplayed entries
    pulse_start(8'd3, 1'b0);
    chk("play_first", line_out, 1);
    chk("play_level", level, 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("play_stop_busy", busy, 0);
    chk("play_stop_level", level, 2);

    // async reset in the middle of playback
    pulse_start(8'd3, 1'b0);
    chk("pre_rst_busy", busy, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_oe", line_oe, 0);
    chk("arst_level", level, 0);
    chk("arst_busy", busy, 0);
    #1;
    rst_n = 1'b1;
    step();
    chk("arst_ready", s_ready, 1);
    chk("arst_idle_out", line_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
